// File: rtl/sdram_arbiter_if.sv
// ----------------------------------------------------------------------------
// sdram_arbiter_if
// Bundles the two requester ports and the SDRAM controller command/return
// port of sdram_arbiter.
//
//   Requester side (m0_*, m1_*):
//     req, rw, addr[23:0], wdata[31:0], step   command from the requester
//     gnt                                      one-cycle command-accepted pulse
//     rdata[31:0], rvalid, rlast               read beats back to the requester
//   Controller side (sd_*):
//     in_valid, rw, addr[23:0], wdata[31:0], step   command to the controller
//     busy, out_valid, rdata[31:0]                  controller status/read data
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives the controller)
//   master - the environment's view (requesters plus controller model)
// ----------------------------------------------------------------------------
interface sdram_arbiter_if;
   logic        m0_req;
   logic        m0_rw;
   logic [23:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_step;
   logic        m0_gnt;
   logic [31:0] m0_rdata;
   logic        m0_rvalid;
   logic        m0_rlast;

   logic        m1_req;
   logic        m1_rw;
   logic [23:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_step;
   logic        m1_gnt;
   logic [31:0] m1_rdata;
   logic        m1_rvalid;
   logic        m1_rlast;

   logic        sd_in_valid;
   logic        sd_rw;
   logic        sd_step;
   logic [23:0] sd_addr;
   logic [31:0] sd_wdata;
   logic        sd_busy;
   logic        sd_out_valid;
   logic [31:0] sd_rdata;

   modport slave (
      input  m0_req, m0_rw, m0_addr, m0_wdata, m0_step,
      output m0_gnt, m0_rdata, m0_rvalid, m0_rlast,
      input  m1_req, m1_rw, m1_addr, m1_wdata, m1_step,
      output m1_gnt, m1_rdata, m1_rvalid, m1_rlast,
      output sd_in_valid, sd_rw, sd_step, sd_addr, sd_wdata,
      input  sd_busy, sd_out_valid, sd_rdata
   );

   modport master (
      output m0_req, m0_rw, m0_addr, m0_wdata, m0_step,
      input  m0_gnt, m0_rdata, m0_rvalid, m0_rlast,
      output m1_req, m1_rw, m1_addr, m1_wdata, m1_step,
      input  m1_gnt, m1_rdata, m1_rvalid, m1_rlast,
      input  sd_in_valid, sd_rw, sd_step, sd_addr, sd_wdata,
      output sd_busy, sd_out_valid, sd_rdata
   );
endinterface

// File: rtl/sdram_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_arbiter
// Two-requester arbiter in front of an SDRAM controller. One command is
// selected in IDLE, presented to the controller in ISSUE until it is accepted
// (sd_in_valid = !sd_busy), and for reads the FSM waits in RD_WAIT for
// READ_BEATS returned beats, which are forwarded one cycle later to the owner.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - sdram_arbiter_if.slave: requester m0/m1 ports and controller port
//
// Parameters:
//   READ_BEATS - beats returned by the controller per read command
//
// Configuration macro:
//   SDRAM_ARB_RR_EN - defined: round-robin on ties (requester not granted
//                     last wins). Undefined: fixed priority, m0 wins ties.
// ----------------------------------------------------------------------------
module sdram_arbiter #(
   parameter int READ_BEATS = 4
) (
   input  logic           clk,
   input  logic           rst,
   sdram_arbiter_if.slave bus
);

   localparam int               CNT_W     = $clog2(READ_BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic             owner_reg;
   logic             cmd_rw_reg;
   logic             cmd_step_reg;
   logic [23:0]      cmd_addr_reg;
   logic [31:0]      cmd_wdata_reg;
   logic [CNT_W-1:0] beat_cnt_reg;

   logic [1:0]       req;
   logic [1:0]       owner_onehot;
   logic             winner;
   logic             select;
   logic             issue_fire;
   logic             beat_in;
   logic             beat_last;

   assign req          = {bus.m1_req, bus.m0_req};
   assign owner_onehot = {owner_reg, ~owner_reg};
   assign select       = (state_reg == IDLE) && (|req);
   // Gated by rst so a command caught in ISSUE during reset is never offered.
   assign issue_fire   = (state_reg == ISSUE) && !bus.sd_busy && !rst;
   // Returned beats are only meaningful while a read is outstanding.
   assign beat_in      = (state_reg == RD_WAIT) && bus.sd_out_valid;
   assign beat_last    = beat_in && (beat_cnt_reg == LAST_BEAT);

`ifdef SDRAM_ARB_RR_EN
   // Remembers who was granted last; resets to m1 so m0 wins the first tie.
   logic last_gnt_reg;

   assign winner = (req == 2'b11) ? ~last_gnt_reg : req[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt_reg <= 1'b1;
      end else if (issue_fire) begin
         last_gnt_reg <= owner_reg;
      end
   end
`else
   // m0 wins whenever it is requesting.
   assign winner = ~req[0];
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (issue_fire) begin
               state_next = cmd_rw_reg ? IDLE : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (beat_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------- command registers
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_reg     <= 1'b0;
         cmd_rw_reg    <= 1'b0;
         cmd_step_reg  <= 1'b0;
         cmd_addr_reg  <= '0;
         cmd_wdata_reg <= '0;
      end else if (select) begin
         owner_reg     <= winner;
         cmd_rw_reg    <= winner ? bus.m1_rw    : bus.m0_rw;
         cmd_step_reg  <= winner ? bus.m1_step  : bus.m0_step;
         cmd_addr_reg  <= winner ? bus.m1_addr  : bus.m0_addr;
         cmd_wdata_reg <= winner ? bus.m1_wdata : bus.m0_wdata;
      end
   end

   // Beat counter clears on the final beat, so it never wraps mid-read.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_reg <= '0;
      end else if (beat_last) begin
         beat_cnt_reg <= '0;
      end else if (beat_in) begin
         beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
   end

   // ------------------------------------------- per-requester read return
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [31:0] rdata_reg;
         logic        rvalid_reg;
         logic        rlast_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_reg  <= '0;
               rvalid_reg <= 1'b0;
               rlast_reg  <= 1'b0;
            end else begin
               rvalid_reg <= beat_in && owner_onehot[gi];
               rlast_reg  <= beat_last && owner_onehot[gi];
               // Non-owner keeps its last read data.
               if (beat_in && owner_onehot[gi]) begin
                  rdata_reg <= bus.sd_rdata;
               end
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------ outputs
   assign bus.m0_gnt    = issue_fire & ~owner_reg;
   assign bus.m1_gnt    = issue_fire &  owner_reg;
   assign bus.m0_rdata  = g_port[0].rdata_reg;
   assign bus.m0_rvalid = g_port[0].rvalid_reg;
   assign bus.m0_rlast  = g_port[0].rlast_reg;
   assign bus.m1_rdata  = g_port[1].rdata_reg;
   assign bus.m1_rvalid = g_port[1].rvalid_reg;
   assign bus.m1_rlast  = g_port[1].rlast_reg;

   assign bus.sd_in_valid = issue_fire;
   assign bus.sd_rw       = cmd_rw_reg;
   assign bus.sd_step     = cmd_step_reg;
   assign bus.sd_addr     = cmd_addr_reg;
   assign bus.sd_wdata    = cmd_wdata_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter (READ_BEATS = 4). Expected commands
// and read beats are queued when stimulus is driven and compared when the
// DUT presents them. Inputs change and outputs are sampled on the falling
// clock edge.
// ----------------------------------------------------------------------------
module tb_sdram_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdram_arbiter_if bus();

   sdram_arbiter #(.READ_BEATS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        port;
      logic        rw;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic        step;
   } cmd_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic        v0;
      logic        v1;
      logic        l0;
      logic        l1;
      logic [31:0] d0;
      logic [31:0] d1;
   } obs_t;

   int          checks   = 0;
   int          failures = 0;
   cmd_t        cmd_q[$];
   beat_t       beat_q[$];
   obs_t        obs_q[$];
   logic [31:0] last_rdata [2];

   // ---------------------------------------------------------- drivers
   task automatic drive_req(input logic port, input logic rw, input logic [23:0] addr,
                            input logic [31:0] wdata, input logic step);
      cmd_t c;
      c.port = port; c.rw = rw; c.addr = addr; c.wdata = wdata; c.step = step;
      cmd_q.push_back(c);
      if (port) begin
         bus.m1_rw = rw; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_step = step;
         bus.m1_req = 1'b1;
      end else begin
         bus.m0_rw = rw; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_step = step;
         bus.m0_req = 1'b1;
      end
   endtask

   // Waits (bounded) for sd_in_valid and reports what was offered.
   task automatic wait_issue(input int budget, output logic seen, output logic g0,
                             output logic g1, output cmd_t o);
      seen = 1'b0; g0 = 1'b0; g1 = 1'b0;
      o.port = 1'b0; o.rw = 1'b0; o.addr = '0; o.wdata = '0; o.step = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.sd_in_valid) begin
            seen   = 1'b1;
            g0     = bus.m0_gnt;
            g1     = bus.m1_gnt;
            o.port = bus.m1_gnt;
            o.rw   = bus.sd_rw;
            o.addr = bus.sd_addr;
            o.wdata = bus.sd_wdata;
            o.step = bus.sd_step;
         end
      end
   endtask

   // Drives n controller beats back to back and records every rvalid cycle.
   task automatic run_beats(input int n, input logic [31:0] d [8]);
      obs_t o;
      obs_q.delete();
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (bus.m0_rvalid || bus.m1_rvalid) begin
            o.v0 = bus.m0_rvalid; o.v1 = bus.m1_rvalid;
            o.l0 = bus.m0_rlast;  o.l1 = bus.m1_rlast;
            o.d0 = bus.m0_rdata;  o.d1 = bus.m1_rdata;
            obs_q.push_back(o);
         end
         if (i < n) begin
            bus.sd_out_valid = 1'b1;
            bus.sd_rdata     = d[i];
         end else begin
            bus.sd_out_valid = 1'b0;
            bus.sd_rdata     = '0;
         end
      end
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset;
      bus.m0_req = 0; bus.m0_rw = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_step = 0;
      bus.m1_req = 0; bus.m1_rw = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_step = 0;
      bus.sd_busy = 0; bus.sd_out_valid = 0; bus.sd_rdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.sd_in_valid, bus.m0_rvalid, bus.m1_rvalid,
           bus.m0_rlast, bus.m1_rlast} !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags observed gnt=%b%b in_valid=%b rvalid=%b%b rlast=%b%b required all 0",
                  bus.m0_gnt, bus.m1_gnt, bus.sd_in_valid, bus.m0_rvalid, bus.m1_rvalid,
                  bus.m0_rlast, bus.m1_rlast);
      end
      checks++;
      if ({bus.sd_rw, bus.sd_step, bus.sd_addr, bus.sd_wdata} !== 58'b0) begin
         failures++;
         $display("FAIL reset_cmd observed rw=%b step=%b addr=%h wdata=%h required 0",
                  bus.sd_rw, bus.sd_step, bus.sd_addr, bus.sd_wdata);
      end
      checks++;
      if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata observed m0=%h m1=%h required 0", bus.m0_rdata, bus.m1_rdata);
      end
      last_rdata[0] = '0;
      last_rdata[1] = '0;
      rst = 1'b0;
      $display("test_reset: done");
   endtask

   task automatic test_write;
      logic seen, g0, g1;
      cmd_t o, e;
      int   rv;
      drive_req(1'b0, 1'b1, 24'h000100, 32'hDEADBEEF, 1'b0);
      wait_issue(20, seen, g0, g1, o);
      bus.m0_req = 1'b0;
      e = cmd_q.pop_front();
      checks++;
      if (!seen || {g1, g0} !== 2'b01 || o.rw !== e.rw || o.addr !== e.addr ||
          o.wdata !== e.wdata || o.step !== e.step) begin
         failures++;
         $display("FAIL write_issue observed seen=%b gnt=%b%b rw=%b addr=%h wdata=%h step=%b required gnt=01 rw=%b addr=%h wdata=%h step=%b",
                  seen, g1, g0, o.rw, o.addr, o.wdata, o.step, e.rw, e.addr, e.wdata, e.step);
      end
      @(negedge clk);
      checks++;
      if (bus.sd_in_valid !== 1'b0 || bus.m0_gnt !== 1'b0) begin
         failures++;
         $display("FAIL write_pulse observed in_valid=%b m0_gnt=%b required 0 0", bus.sd_in_valid, bus.m0_gnt);
      end
      rv = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.m0_rvalid || bus.m1_rvalid) rv++;
      end
      checks++;
      if (rv != 0) begin
         failures++;
         $display("FAIL write_no_rvalid observed %0d rvalid cycles required 0", rv);
      end
      $display("test_write: addr=%h data=%h", o.addr, o.wdata);
   endtask

   task automatic test_drop_idle;
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0 && (bus.m0_rvalid || bus.m1_rvalid || bus.m0_rdata !== last_rdata[0] ||
                       bus.m1_rdata !== last_rdata[1])) bad++;
         bus.sd_out_valid = (i < 3);
         bus.sd_rdata     = 32'hBAD0_0000 + 32'(i);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL drop_idle observed %0d cycles with requester output required 0", bad);
      end
      $display("test_drop_idle: done");
   endtask

   task automatic test_read;
      logic        seen, g0, g1;
      cmd_t        o, e;
      beat_t       b;
      obs_t        ob;
      logic [1:0]  vexp;
      logic [31:0] d [8];
      drive_req(1'b1, 1'b0, 24'h000200, 32'h0, 1'b1);
      wait_issue(20, seen, g0, g1, o);
      bus.m1_req = 1'b0;
      e = cmd_q.pop_front();
      checks++;
      if (!seen || {g1, g0} !== 2'b10 || o.rw !== e.rw || o.addr !== e.addr || o.step !== e.step) begin
         failures++;
         $display("FAIL read_issue observed seen=%b gnt=%b%b rw=%b addr=%h step=%b required gnt=10 rw=%b addr=%h step=%b",
                  seen, g1, g0, o.rw, o.addr, o.step, e.rw, e.addr, e.step);
      end
      d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 4; i++) begin
         b.port = 1'b1; b.data = d[i]; b.last = (i == 3);
         beat_q.push_back(b);
      end
      run_beats(4, d);
      while (beat_q.size() > 0) begin
         b = beat_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL read_beat observed none required data=%h", b.data);
         end else begin
            ob   = obs_q.pop_front();
            vexp = b.port ? 2'b10 : 2'b01;
            if ({ob.v1, ob.v0} !== vexp || (b.port ? ob.d1 : ob.d0) !== b.data ||
                {ob.l1, ob.l0} !== (b.last ? vexp : 2'b00) ||
                (b.port ? ob.d0 : ob.d1) !== last_rdata[b.port ? 0 : 1]) begin
               failures++;
               $display("FAIL read_beat observed rvalid=%b%b rlast=%b%b d0=%h d1=%h required port=%0d data=%h last=%b",
                        ob.v1, ob.v0, ob.l1, ob.l0, ob.d0, ob.d1, b.port, b.data, b.last);
            end
            last_rdata[b.port ? 1 : 0] = b.data;
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL read_extra observed %0d extra beats required 0", obs_q.size());
      end
      $display("test_read: m1 addr=%h 4 beats", o.addr);
   endtask

   task automatic test_busy;
      logic seen, g0, g1;
      cmd_t o, e;
      bus.sd_busy      = 1'b1;
      bus.sd_out_valid = 1'b1;
      bus.sd_rdata     = 32'hFFFF_0000;
      drive_req(1'b0, 1'b1, 24'h0ABCDE, 32'h12345678, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (bus.sd_in_valid !== 1'b0 || bus.m0_gnt !== 1'b0 || bus.m0_rvalid !== 1'b0 ||
             bus.sd_addr !== 24'h0ABCDE) begin
            failures++;
            $display("FAIL busy_hold cycle=%0d observed in_valid=%b gnt=%b rvalid=%b addr=%h required 0 0 0 0abcde",
                     i, bus.sd_in_valid, bus.m0_gnt, bus.m0_rvalid, bus.sd_addr);
         end
      end
      bus.sd_busy      = 1'b0;
      bus.sd_out_valid = 1'b0;
      wait_issue(3, seen, g0, g1, o);
      bus.m0_req = 1'b0;
      e = cmd_q.pop_front();
      checks++;
      if (!seen || {g1, g0} !== 2'b01 || o.rw !== e.rw || o.addr !== e.addr ||
          o.wdata !== e.wdata || o.step !== e.step) begin
         failures++;
         $display("FAIL busy_issue observed seen=%b gnt=%b%b rw=%b addr=%h wdata=%h step=%b required gnt=01 rw=%b addr=%h wdata=%h step=%b",
                  seen, g1, g0, o.rw, o.addr, o.wdata, o.step, e.rw, e.addr, e.wdata, e.step);
      end
      @(negedge clk);
      checks++;
      if (bus.sd_in_valid !== 1'b0 || bus.m0_gnt !== 1'b0) begin
         failures++;
         $display("FAIL busy_single_pulse observed in_valid=%b gnt=%b required 0 0", bus.sd_in_valid, bus.m0_gnt);
      end
      $display("test_busy: issued after busy fell");
   endtask

   task automatic test_reset_mid_read;
      logic        seen, g0, g1;
      cmd_t        o, e;
      beat_t       b;
      obs_t        ob;
      logic [1:0]  vexp;
      logic [31:0] d [8];
      drive_req(1'b1, 1'b0, 24'h000600, 32'h0, 1'b0);
      wait_issue(20, seen, g0, g1, o);
      bus.m1_req = 1'b0;
      e = cmd_q.pop_front();
      checks++;
      if (!seen || {g1, g0} !== 2'b10 || o.addr !== e.addr || o.rw !== e.rw) begin
         failures++;
         $display("FAIL rstmid_issue observed seen=%b gnt=%b%b addr=%h rw=%b required gnt=10 addr=%h rw=%b",
                  seen, g1, g0, o.addr, o.rw, e.addr, e.rw);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1 || i == 2) begin
            checks++;
            if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'h50 + 32'(i)) begin
               failures++;
               $display("FAIL rstmid_beat%0d observed rvalid=%b data=%h required 1 %h",
                        i, bus.m1_rvalid, bus.m1_rdata, 32'h50 + 32'(i));
            end
         end
         if (i == 3) begin
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.sd_in_valid, bus.m0_rvalid, bus.m1_rvalid,
                 bus.m0_rlast, bus.m1_rlast} !== 7'b0 || bus.m1_rdata !== 32'h0 ||
                bus.sd_addr !== 24'h0) begin
               failures++;
               $display("FAIL rstmid_cleared observed rvalid=%b%b rlast=%b%b in_valid=%b m1_rdata=%h addr=%h required all 0",
                        bus.m1_rvalid, bus.m0_rvalid, bus.m1_rlast, bus.m0_rlast,
                        bus.sd_in_valid, bus.m1_rdata, bus.sd_addr);
            end
         end
         if (i >= 4) begin
            checks++;
            if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
               failures++;
               $display("FAIL rstmid_dropped%0d observed rvalid=%b%b required 00", i, bus.m1_rvalid, bus.m0_rvalid);
            end
         end
         rst              = (i == 2);
         bus.sd_out_valid = (i < 4);
         bus.sd_rdata     = 32'h51 + 32'(i);
      end
      last_rdata[0] = '0;
      last_rdata[1] = '0;
      drive_req(1'b0, 1'b0, 24'h000700, 32'h0, 1'b0);
      wait_issue(20, seen, g0, g1, o);
      bus.m0_req = 1'b0;
      e = cmd_q.pop_front();
      checks++;
      if (!seen || {g1, g0} !== 2'b01 || o.addr !== e.addr || o.rw !== e.rw) begin
         failures++;
         $display("FAIL rstmid_next_issue observed seen=%b gnt=%b%b addr=%h required gnt=01 addr=%h",
                  seen, g1, g0, o.addr, e.addr);
      end
      d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 4; i++) begin
         b.port = 1'b0; b.data = d[i]; b.last = (i == 3);
         beat_q.push_back(b);
      end
      run_beats(4, d);
      while (beat_q.size() > 0) begin
         b = beat_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL rstmid_next_beat observed none required data=%h", b.data);
         end else begin
            ob   = obs_q.pop_front();
            vexp = b.port ? 2'b10 : 2'b01;
            if ({ob.v1, ob.v0} !== vexp || (b.port ? ob.d1 : ob.d0) !== b.data ||
                {ob.l1, ob.l0} !== (b.last ? vexp : 2'b00) ||
                (b.port ? ob.d0 : ob.d1) !== last_rdata[b.port ? 0 : 1]) begin
               failures++;
               $display("FAIL rstmid_next_beat observed rvalid=%b%b rlast=%b%b d0=%h d1=%h required port=%0d data=%h last=%b",
                        ob.v1, ob.v0, ob.l1, ob.l0, ob.d0, ob.d1, b.port, b.data, b.last);
            end
            last_rdata[b.port ? 1 : 0] = b.data;
         end
      end
      $display("test_reset_mid_read: aborted read, next m0 read served");
   endtask

   task automatic test_tie;
      logic        seen, g0, g1;
      logic        exp_port;
      cmd_t        o, e;
      beat_t       b;
      obs_t        ob;
      logic [1:0]  vexp;
      logic [31:0] d [8];
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_rdata[0] = '0;
      last_rdata[1] = '0;
      bus.m0_rw = 1'b0; bus.m0_addr = 24'h000300; bus.m0_wdata = 32'h3333; bus.m0_step = 1'b0;
      bus.m1_rw = 1'b0; bus.m1_addr = 24'h000400; bus.m1_wdata = 32'h4444; bus.m1_step = 1'b1;
      bus.m0_req = 1'b1;
      bus.m1_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_RR_EN
         exp_port = (k % 2) == 1;
`else
         exp_port = 1'b0;
`endif
         e.port  = exp_port;
         e.rw    = 1'b0;
         e.addr  = exp_port ? 24'h000400 : 24'h000300;
         e.wdata = exp_port ? 32'h4444 : 32'h3333;
         e.step  = exp_port;
         cmd_q.push_back(e);
         wait_issue(20, seen, g0, g1, o);
         if (k == 3) begin
            bus.m0_req = 1'b0;
            bus.m1_req = 1'b0;
         end
         e = cmd_q.pop_front();
         checks++;
         if (!seen || {g1, g0} !== (e.port ? 2'b10 : 2'b01) || o.addr !== e.addr || o.step !== e.step) begin
            failures++;
            $display("FAIL tie_grant%0d observed seen=%b gnt=%b%b addr=%h step=%b required port=%0d addr=%h step=%b",
                     k, seen, g1, g0, o.addr, o.step, e.port, e.addr, e.step);
         end
         for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + 32'(k * 16 + i);
         for (int i = 0; i < 4; i++) begin
            b.port = exp_port; b.data = d[i]; b.last = (i == 3);
            beat_q.push_back(b);
         end
         run_beats(4, d);
         while (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
               failures++;
               $display("FAIL tie_beat%0d observed none required data=%h", k, b.data);
            end else begin
               ob   = obs_q.pop_front();
               vexp = b.port ? 2'b10 : 2'b01;
               if ({ob.v1, ob.v0} !== vexp || (b.port ? ob.d1 : ob.d0) !== b.data ||
                   {ob.l1, ob.l0} !== (b.last ? vexp : 2'b00) ||
                   (b.port ? ob.d0 : ob.d1) !== last_rdata[b.port ? 0 : 1]) begin
                  failures++;
                  $display("FAIL tie_beat%0d observed rvalid=%b%b rlast=%b%b d0=%h d1=%h required port=%0d data=%h last=%b",
                           k, ob.v1, ob.v0, ob.l1, ob.l0, ob.d0, ob.d1, b.port, b.data, b.last);
               end
               last_rdata[b.port ? 1 : 0] = b.data;
            end
         end
         $display("test_tie: selection %0d granted m%0d", k, o.port);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_drop_idle();
      test_read();
      test_busy();
      test_reset_mid_read();
      test_tie();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: READ_BEATS, 4, number of sd_out_valid beats returned per read command.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: m0_req / m1_req  input  1  requester command pending; held high until the matching grant.
REQ-005 Port: m0_rw / m1_rw  input  1  1 = write, 0 = read.
REQ-006 Port: m0_addr / m1_addr  input  24  user address.
REQ-007 Port: m0_wdata / m1_wdata  input  32  write data.
REQ-008 Port: m0_step / m1_step  input  1  prefetch step (0 = +1 column, 1 = +4 columns).
REQ-009 Port: m0_gnt / m1_gnt  output  1  one-cycle pulse: command accepted by the controller.
REQ-010 Port: m0_rdata / m1_rdata  output  32  read beat data.
REQ-011 Port: m0_rvalid / m1_rvalid  output  1  read beat valid.
REQ-012 Port: m0_rlast / m1_rlast  output  1  high with the final read beat.
REQ-013 Port: sd_in_valid, sd_rw, sd_step  output  1 each  controller command handshake and fields.
REQ-014 Port: sd_addr  output  24; sd_wdata  output  32  controller command fields.
REQ-015 Port: sd_busy  input  1; sd_out_valid  input  1; sd_rdata  input  32  controller status and read return.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, RD_WAIT.
REQ-017 IDLE: if any req high, select winner, latch owner/rw/addr/wdata/step into command registers, go ISSUE; else stay.
REQ-018 ISSUE: sd_in_valid = !sd_busy (combinational); same cycle pulse gnt of owner; on that cycle go IDLE for write, RD_WAIT for read; while sd_busy high, hold ISSUE.
REQ-019 sd_rw/sd_addr/sd_wdata/sd_step SHALL be driven from the command registers at all times.
REQ-020 ISSUE SHALL never assert sd_in_valid on two consecutive cycles; the mandatory IDLE cycle covers the controller's one-cycle busy lag.
REQ-021 RD_WAIT: each sd_out_valid beat SHALL be registered to owner rdata/rvalid one cycle later; beat counter increments per beat.
REQ-022 On beat READ_BEATS, owner rlast SHALL assert with that beat, counter clears, FSM goes IDLE; only one read outstanding at a time.
REQ-023 The non-owner's rvalid/rlast SHALL stay 0; rdata of non-owner holds its last value.
REQ-024 sd_out_valid seen in IDLE or ISSUE SHALL be dropped without any requester output.
REQ-025 Simultaneous m0_req and m1_req SHALL be resolved per REQ-030/031; the loser keeps req high and is served next selection.
REQ-026 Beat counter width SHALL be clog2(READ_BEATS)+1; it never wraps mid-read.

Reset
REQ-027 On rst: state IDLE, beat counter 0, all gnt/rvalid/rlast/sd_in_valid 0, rdata/command registers 0.
REQ-028 rst during ISSUE or RD_WAIT SHALL abort the command; pending beats after reset are dropped per REQ-024.
REQ-029 Round-robin pointer SHALL reset so m0 wins the first tie.

Configuration
REQ-030 With SDRAM_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins; pointer updates on each gnt.
REQ-031 Without SDRAM_ARB_RR_EN: fixed priority, m0 always wins ties; no pointer register exists.

Verification
REQ-032 m0 write addr 0x000100 data 0xDEADBEEF, sd_busy 0 -> sd_in_valid 1 cycle with sd_rw 1, sd_addr 0x000100, m0_gnt pulse, no rvalid.
REQ-033 m1 read addr 0x000200, controller returns 0x11,0x22,0x33,0x44 -> m1_rvalid 4 cycles, same data one cycle late, m1_rlast on 0x44.
REQ-034 Both req read in same cycle, RR_EN defined, repeated 4 times -> grants alternate m0,m1,m0,m1; RR_EN undefined -> m0 every tie.
REQ-035 sd_busy held high 10 cycles in ISSUE -> no sd_in_valid/gnt until busy falls, then single pulse; sd_addr stable throughout.
REQ-036 rst asserted after 2 read beats -> all outputs 0 next cycle; remaining 2 beats produce no rvalid; next request served normally.
